// File: rtl/jtag_dtm_tap.sv
// JTAG debug transport module: an IEEE 1149.1 TAP controller that runs
// entirely in the clk domain. TCK/TMS/TDI are synchronised and TCK edges
// become single-cycle strobes. Behind the TAP sit the IDCODE, DTMCS, DMI and
// BYPASS registers. DMI scans turn into requests on a valid/ready port, and
// the debug module answers with a single-cycle response strobe.
module jtag_dtm_tap #(
    parameter logic [31:0] IDCODE   = 32'h1E200A6D,
    parameter logic [2:0]  DMI_IDLE = 3'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jtag_TCK,
    input  logic        jtag_TMS,
    input  logic        jtag_TDI,
    output logic        jtag_TDO,
    output logic        dtm_req_valid,
    input  logic        dtm_req_ready,
    output logic [39:0] dtm_req_data,
    input  logic        dm_resp_valid,
    input  logic [31:0] dm_resp_data
);

    typedef enum logic [3:0] {
        S_TLR,
        S_RTI,
        S_SEL_DR,
        S_CAP_DR,
        S_SHIFT_DR,
        S_EXIT1_DR,
        S_PAUSE_DR,
        S_EXIT2_DR,
        S_UPD_DR,
        S_SEL_IR,
        S_CAP_IR,
        S_SHIFT_IR,
        S_EXIT1_IR,
        S_PAUSE_IR,
        S_EXIT2_IR,
        S_UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_DTMCS,
        DR_DMI
    } dr_sel_e;

    // ------------------------------------------------------------------
    // Input synchronisers: bit 0 = TCK, bit 1 = TMS, bit 2 = TDI
    // ------------------------------------------------------------------
    logic [2:0] jtag_raw;
    logic [2:0] jtag_sync;

    assign jtag_raw = {jtag_TDI, jtag_TMS, jtag_TCK};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_q;
            logic stable_q;

            // Two-flop synchroniser per JTAG input; resets to low
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    meta_q   <= 1'b0;
                    stable_q <= 1'b0;
                end else begin
                    meta_q   <= jtag_raw[gi];
                    stable_q <= meta_q;
                end
            end

            assign jtag_sync[gi] = stable_q;
        end
    endgenerate

    logic tck_s;
    logic tms_s;
    logic tdi_s;
    logic tck_prev_q;
    logic tck_rise;
    logic tck_fall;

    assign tck_s = jtag_sync[0];
    assign tms_s = jtag_sync[1];
    assign tdi_s = jtag_sync[2];

    // Delayed copy of synchronised TCK for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tck_prev_q <= 1'b0;
        end else begin
            tck_prev_q <= tck_s;
        end
    end

    assign tck_rise = tck_s & ~tck_prev_q;
    assign tck_fall = ~tck_s & tck_prev_q;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    tap_state_e  state_q,       state_d;
    tap_state_e  tap_next;
    logic [4:0]  ir_q,          ir_d;
    logic [39:0] shift_q,       shift_d;
    logic [31:0] resp_data_q,   resp_data_d;
    logic [5:0]  last_addr_q,   last_addr_d;
    logic        busy_q,        busy_d;
    logic        sticky_q,      sticky_d;
    logic        req_valid_q,   req_valid_d;
    logic [39:0] req_data_q,    req_data_d;
    logic        tdo_q,         tdo_d;

    // TAP next-state table, advanced only on a synchronised TCK rising edge
    always_comb begin
        tap_next = state_q;
        case (state_q)
            S_TLR:      tap_next = tms_s ? S_TLR      : S_RTI;
            S_RTI:      tap_next = tms_s ? S_SEL_DR   : S_RTI;
            S_SEL_DR:   tap_next = tms_s ? S_SEL_IR   : S_CAP_DR;
            S_CAP_DR:   tap_next = tms_s ? S_EXIT1_DR : S_SHIFT_DR;
            S_SHIFT_DR: tap_next = tms_s ? S_EXIT1_DR : S_SHIFT_DR;
            S_EXIT1_DR: tap_next = tms_s ? S_UPD_DR   : S_PAUSE_DR;
            S_PAUSE_DR: tap_next = tms_s ? S_EXIT2_DR : S_PAUSE_DR;
            S_EXIT2_DR: tap_next = tms_s ? S_UPD_DR   : S_SHIFT_DR;
            S_UPD_DR:   tap_next = tms_s ? S_SEL_DR   : S_RTI;
            S_SEL_IR:   tap_next = tms_s ? S_TLR      : S_CAP_IR;
            S_CAP_IR:   tap_next = tms_s ? S_EXIT1_IR : S_SHIFT_IR;
            S_SHIFT_IR: tap_next = tms_s ? S_EXIT1_IR : S_SHIFT_IR;
            S_EXIT1_IR: tap_next = tms_s ? S_UPD_IR   : S_PAUSE_IR;
            S_PAUSE_IR: tap_next = tms_s ? S_EXIT2_IR : S_PAUSE_IR;
            S_EXIT2_IR: tap_next = tms_s ? S_UPD_IR   : S_SHIFT_IR;
            S_UPD_IR:   tap_next = tms_s ? S_SEL_DR   : S_RTI;
            default:    tap_next = S_TLR;
        endcase
        state_d = tck_rise ? tap_next : state_q;
    end

    // ------------------------------------------------------------------
    // Register selection and capture values
    // ------------------------------------------------------------------
    dr_sel_e     dr_sel;
    logic        resp_take;
    logic [31:0] resp_data_now;
    logic        pending;
    logic [1:0]  dmistat;
    logic [31:0] dtmcs_cap;
    logic [39:0] dmi_cap;
    logic        upd_ir;
    logic        upd_dr;
    logic        dmi_upd;
    logic        dmi_rw;
    logic        issue;

    // Decode the instruction register into the selected data register
    always_comb begin
        dr_sel = DR_BYPASS;
        case (ir_q)
            5'h01:   dr_sel = DR_IDCODE;
            5'h10:   dr_sel = DR_DTMCS;
            5'h11:   dr_sel = DR_DMI;
            default: dr_sel = DR_BYPASS;
        endcase
    end

    // A response arriving in the same cycle as a capture or update is folded
    // in first, so the scan sees the fresh data and the cleared busy flag.
    assign resp_take     = dm_resp_valid & busy_q;
    assign resp_data_now = resp_take ? dm_resp_data : resp_data_q;
    // A request counts as outstanding until both the handshake and the
    // response have happened.
    assign pending       = (busy_q & ~resp_take) | req_valid_q;
    assign dmistat       = (pending | sticky_q) ? 2'b11 : 2'b00;
    assign dtmcs_cap     = {14'b0, 1'b0, 1'b0, 1'b0, DMI_IDLE, dmistat, 6'd6, 4'd1};
    assign dmi_cap       = {last_addr_q, resp_data_now, dmistat};

    // Updates fire on the falling TCK edge inside Update-IR / Update-DR
    assign upd_ir  = tck_fall && (state_q == S_UPD_IR);
    assign upd_dr  = tck_fall && (state_q == S_UPD_DR);
    assign dmi_upd = upd_dr && (dr_sel == DR_DMI);
    assign dmi_rw  = (shift_q[1:0] == 2'b01) || (shift_q[1:0] == 2'b10);
    assign issue   = dmi_upd && dmi_rw && !pending && !sticky_q;

    // Shift register: capture on the rising edge in Capture-*, shift in Shift-*
    always_comb begin
        shift_d = shift_q;
        if (tck_rise) begin
            case (state_q)
                S_CAP_IR:   shift_d = 40'd1;
                S_SHIFT_IR: shift_d = {35'b0, tdi_s, shift_q[4:1]};
                S_CAP_DR: begin
                    case (dr_sel)
                        DR_IDCODE: shift_d = {8'b0, IDCODE};
                        DR_DTMCS:  shift_d = {8'b0, dtmcs_cap};
                        DR_DMI:    shift_d = dmi_cap;
                        default:   shift_d = 40'd0;
                    endcase
                end
                S_SHIFT_DR: begin
                    case (dr_sel)
                        DR_IDCODE,
                        DR_DTMCS:  shift_d = {8'b0, tdi_s, shift_q[31:1]};
                        DR_DMI:    shift_d = {tdi_s, shift_q[39:1]};
                        default:   shift_d = {39'b0, tdi_s};
                    endcase
                end
                default:    shift_d = shift_q;
            endcase
        end
    end

    // Instruction, DMI bookkeeping, request port and TDO next-state logic
    always_comb begin
        ir_d        = ir_q;
        sticky_d    = sticky_q;
        busy_d      = busy_q;
        resp_data_d = resp_data_q;
        last_addr_d = last_addr_q;
        req_valid_d = req_valid_q;
        req_data_d  = req_data_q;
        tdo_d       = tdo_q;

        // Test-Logic-Reset reselects IDCODE and clears the sticky error, but
        // leaves any in-flight request on the DMI side alone.
        if (state_q == S_TLR) begin
            ir_d = 5'h01;
        end else if (upd_ir) begin
            ir_d = shift_q[4:0];
        end

        if (state_q == S_TLR) begin
            sticky_d = 1'b0;
        end else if (dmi_upd && pending) begin
            sticky_d = 1'b1;
        end else if (upd_dr && (dr_sel == DR_DTMCS) && shift_q[16]) begin
            sticky_d = 1'b0;
        end

        if (resp_take) begin
            resp_data_d = dm_resp_data;
        end

        if (issue) begin
            busy_d      = 1'b1;
            last_addr_d = shift_q[39:34];
            req_data_d  = shift_q;
            req_valid_d = 1'b1;
        end else begin
            if (resp_take) begin
                busy_d = 1'b0;
            end
            if (req_valid_q && dtm_req_ready) begin
                req_valid_d = 1'b0;
            end
        end

        if (tck_fall) begin
            tdo_d = ((state_q == S_SHIFT_IR) || (state_q == S_SHIFT_DR)) ? shift_q[0] : 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_TLR;
            ir_q        <= 5'h01;
            shift_q     <= 40'd0;
            resp_data_q <= 32'd0;
            last_addr_q <= 6'd0;
            busy_q      <= 1'b0;
            sticky_q    <= 1'b0;
            req_valid_q <= 1'b0;
            req_data_q  <= 40'd0;
            tdo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            shift_q     <= shift_d;
            resp_data_q <= resp_data_d;
            last_addr_q <= last_addr_d;
            busy_q      <= busy_d;
            sticky_q    <= sticky_d;
            req_valid_q <= req_valid_d;
            req_data_q  <= req_data_d;
            tdo_q       <= tdo_d;
        end
    end

    assign jtag_TDO      = tdo_q;
    assign dtm_req_valid = req_valid_q;
    assign dtm_req_data  = req_data_q;

endmodule

// File: tb/tb_jtag_dtm_tap.sv
// Directed bench for jtag_dtm_tap: bit-bangs JTAG scans with slow TCK phases,
// plays the debug-module side by hand and compares every scan-out and
// request against hand-computed values.
module tb_jtag_dtm_tap;

    logic        clk;
    logic        rst;
    logic        jtag_TCK;
    logic        jtag_TMS;
    logic        jtag_TDI;
    logic        jtag_TDO;
    logic        dtm_req_valid;
    logic        dtm_req_ready;
    logic [39:0] dtm_req_data;
    logic        dm_resp_valid;
    logic [31:0] dm_resp_data;

    int total;
    int bad;

    jtag_dtm_tap dut (
        .clk           (clk),
        .rst           (rst),
        .jtag_TCK      (jtag_TCK),
        .jtag_TMS      (jtag_TMS),
        .jtag_TDI      (jtag_TDI),
        .jtag_TDO      (jtag_TDO),
        .dtm_req_valid (dtm_req_valid),
        .dtm_req_ready (dtm_req_ready),
        .dtm_req_data  (dtm_req_data),
        .dm_resp_valid (dm_resp_valid),
        .dm_resp_data  (dm_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("check %s: got=%h exp=%h ok", tag, got, exp);
        end
    endtask

    // One full TCK period; returns TDO as seen after the falling edge
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
        @(negedge clk);
        jtag_TMS = tms;
        jtag_TDI = tdi;
        repeat (3) @(negedge clk);
        jtag_TCK = 1'b1;
        repeat (5) @(negedge clk);
        jtag_TCK = 1'b0;
        repeat (6) @(negedge clk);
        tdo = jtag_TDO;
    endtask

    // From Run-Test/Idle into Shift-DR or Shift-IR; first = bit 0 on TDO
    task automatic goto_shift(input logic ir, output logic first);
        logic t;
        tck_cycle(1'b1, 1'b0, t);
        if (ir) tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, first);
    endtask

    // Shift n bits LSB first, leaving the TAP in Exit1
    task automatic shift_n(input logic [39:0] din, input int n, input logic first,
                           output logic [39:0] dout);
        logic b;
        b    = first;
        dout = 40'd0;
        for (int i = 0; i < n; i++) begin
            dout[i] = b;
            tck_cycle(i == n - 1, din[i], b);
        end
    endtask

    // Exit1 -> Update -> Run-Test/Idle
    task automatic finish_scan;
        logic t;
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
    endtask

    task automatic scan(input logic ir, input logic [39:0] din, input int n,
                        output logic [39:0] dout);
        logic f;
        goto_shift(ir, f);
        shift_n(din, n, f, dout);
        finish_scan();
    endtask

    task automatic handshake;
        @(negedge clk);
        dtm_req_ready = 1'b1;
        @(negedge clk);
        dtm_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        @(negedge clk);
        dm_resp_valid = 1'b1;
        dm_resp_data  = d;
        @(negedge clk);
        dm_resp_valid = 1'b0;
        dm_resp_data  = 32'd0;
    endtask

    initial begin
        logic [39:0] o;
        logic        f;
        logic        t;
        int          k;

        total         = 0;
        bad           = 0;
        rst           = 1'b0;
        jtag_TCK      = 1'b0;
        jtag_TMS      = 1'b1;
        jtag_TDI      = 1'b0;
        dtm_req_ready = 1'b0;
        dm_resp_valid = 1'b0;
        dm_resp_data  = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst_tdo",   40'(jtag_TDO), 40'd0);
        chk("rst_valid", 40'(dtm_req_valid), 40'd0);
        chk("rst_data",  dtm_req_data, 40'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Test-Logic-Reset -> Run-Test/Idle, default IR reads IDCODE
        tck_cycle(1'b0, 1'b0, t);
        scan(1'b0, 40'd0, 32, o);
        chk("idcode", o, 40'h001E200A6D);

        // DTMCS selection and idle capture value
        scan(1'b1, 40'h10, 5, o);
        chk("ir_capture", o, 40'h01);
        scan(1'b0, 40'd0, 32, o);
        chk("dtmcs_idle", o, 40'h0000005061);

        // BYPASS: captured 0 then input delayed by one bit
        scan(1'b1, 40'h1F, 5, o);
        scan(1'b0, 40'hB2, 8, o);
        chk("bypass", o, 40'h64);

        // DMI write: request timing, hold and handshake
        scan(1'b1, 40'h11, 5, o);
        goto_shift(1'b0, f);
        shift_n(40'h4000000002, 40, f, o);
        chk("dmi_cap0", o, 40'd0);
        @(negedge clk);
        jtag_TMS = 1'b1;
        repeat (3) @(negedge clk);
        jtag_TCK = 1'b1;
        repeat (5) @(negedge clk);
        chk("req_early", 40'(dtm_req_valid), 40'd0);
        jtag_TCK = 1'b0;
        k = 0;
        while (!dtm_req_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("req_latency", 40'(k), 40'd3);
        chk("req_wr_data", dtm_req_data, 40'h4000000002);
        repeat (10) @(negedge clk);
        chk("req_hold", 40'(dtm_req_valid), 40'd1);
        chk("req_stable", dtm_req_data, 40'h4000000002);
        dtm_req_ready = 1'b1;
        @(negedge clk);
        dtm_req_ready = 1'b0;
        chk("req_drop", 40'(dtm_req_valid), 40'd0);
        tck_cycle(1'b0, 1'b0, t);
        respond(32'hCAFEF00D);

        // DMI read; capture shows the previous write's address and response
        scan(1'b0, {6'h11, 32'h0, 2'b01}, 40, o);
        chk("dmi_cap1", o, {6'h10, 32'hCAFEF00D, 2'b00});
        chk("req_rd_data", dtm_req_data, {6'h11, 32'h0, 2'b01});
        handshake();
        respond(32'hDEADBEEF);
        respond(32'h12345678);
        scan(1'b0, 40'd0, 40, o);
        chk("dmi_rd_resp", o, {6'h11, 32'hDEADBEEF, 2'b00});
        chk("nop_no_req", 40'(dtm_req_valid), 40'd0);

        // Update while busy: no new request, sticky error until cleared
        scan(1'b0, {6'h05, 32'h11223344, 2'b10}, 40, o);
        scan(1'b0, {6'h06, 32'h55667788, 2'b10}, 40, o);
        chk("busy_cap", o, {6'h05, 32'hDEADBEEF, 2'b11});
        chk("busy_keep_data", dtm_req_data, {6'h05, 32'h11223344, 2'b10});
        chk("busy_keep_valid", 40'(dtm_req_valid), 40'd1);
        scan(1'b0, 40'd0, 40, o);
        chk("sticky_cap", o, {6'h05, 32'hDEADBEEF, 2'b11});
        scan(1'b1, 40'h10, 5, o);
        scan(1'b0, 40'h10000, 32, o);
        chk("dtmcs_err", o, 40'h0000005C61);
        handshake();
        respond(32'hA5A5A5A5);
        scan(1'b0, 40'd0, 32, o);
        chk("dtmcs_clear", o, 40'h0000005061);
        scan(1'b1, 40'h11, 5, o);
        scan(1'b0, 40'd0, 40, o);
        chk("dmi_after_clr", o, {6'h05, 32'hA5A5A5A5, 2'b00});

        // TAP reset keeps the request; then reset pulse mid Shift-DR
        scan(1'b0, {6'h07, 32'h0BADF00D, 2'b10}, 40, o);
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t);
        chk("tlr_keeps_req", 40'(dtm_req_valid), 40'd1);
        tck_cycle(1'b0, 1'b0, t);
        goto_shift(1'b0, f);
        chk("tlr_idcode_b0", 40'(f), 40'd1);
        for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b0, t);
        chk("mid_shift_tdo", 40'(t), 40'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_tdo",   40'(jtag_TDO), 40'd0);
        chk("arst_valid", 40'(dtm_req_valid), 40'd0);
        chk("arst_data",  dtm_req_data, 40'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tck_cycle(1'b0, 1'b0, t);
        scan(1'b0, 40'd0, 32, o);
        chk("idcode_after_rst", o, 40'h001E200A6D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtag_dtm_tap.md
JTAG_DTM_TAP -- requirements
Module: jtag_dtm_tap

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1E200A6D, value captured by the IDCODE data register.
REQ-002 SHALL have parameter DMI_IDLE, default 3'd5, value reported in the DTMCS idle field.
REQ-003 SHALL have port clk, input, 1, single system clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port jtag_TCK, input, 1, JTAG test clock, sampled in the clk domain.
REQ-006 SHALL have port jtag_TMS, input, 1, JTAG mode select.
REQ-007 SHALL have port jtag_TDI, input, 1, JTAG serial data in, LSB first.
REQ-008 SHALL have port jtag_TDO, output, 1, JTAG serial data out.
REQ-009 SHALL have port dtm_req_valid, output, 1, DMI request pending.
REQ-010 SHALL have port dtm_req_ready, input, 1, debug module accepts the request.
REQ-011 SHALL have port dtm_req_data, output, 40, request {addr[39:34], data[33:2], op[1:0]}.
REQ-012 SHALL have port dm_resp_valid, input, 1, one-cycle response strobe.
REQ-013 SHALL have port dm_resp_data, input, 32, response read data.

Function
REQ-014 SHALL pass jtag_TCK, jtag_TMS and jtag_TDI through 2-flop synchronizers and detect TCK rising and falling edges in the clk domain.
- Each TCK high and low phase is at least 4 clk periods.
REQ-015 SHALL implement the 16-state IEEE 1149.1 TAP FSM:
- Test-Logic-Reset, Run-Test/Idle, Select-DR/IR, Capture-, Shift-, Exit1-, Pause-, Exit2-, Update-DR/IR.
- Transitions on each synchronized TCK rising edge, per synchronized TMS.
REQ-016 SHALL select the IR (5 bits) on the Capture-IR edge and load it with 5'b00001.
- Shift-IR shifts TDI into bit 4 and right-shifts.
- Update-IR commits the shifted value to ir_reg.
REQ-017 SHALL decode ir_reg as follows:
- 0x01: IDCODE, 32-bit.
- 0x10: DTMCS, 32-bit.
- 0x11: DMI, 40-bit.
- any other value: BYPASS, 1-bit, captures 0.
REQ-018 DTMCS capture value SHALL be {14'b0, dmihardreset 0, dmireset 0, 1'b0, DMI_IDLE, dmistat[1:0], abits 6'd6, version 4'd1}.
REQ-019 Update-DR with DTMCS selected and shifted bit 16 = 1 SHALL clear sticky dmistat to 0.
REQ-020 DMI capture value SHALL be {last_addr[5:0], resp_data[31:0], dmistat[1:0]}.
- dmistat = 3 while a request is pending or the sticky error is set.
REQ-021 Shift-DR SHALL shift TDI into the MSB of the selected register and right-shift.
REQ-022 jtag_TDO SHALL update on the synchronized TCK falling edge to shift_reg[0] in Shift-IR/Shift-DR, else 0.
REQ-023 Update-DR with DMI selected and op = 1 or 2, when idle and not sticky, SHALL load dtm_req_data with the shifted 40 bits and set dtm_req_valid the following clk.
REQ-024 dtm_req_valid SHALL stay high until the cycle dtm_req_valid and dtm_req_ready are both 1, then drop the next clk.
- dtm_req_data SHALL be held stable while dtm_req_valid is high.
REQ-025 The module SHALL be busy from request issue until dm_resp_valid.
- On dm_resp_valid it latches dm_resp_data into resp_data and clears busy.
- dm_resp_valid while not busy SHALL be ignored.
REQ-026 Update-DR with DMI selected while busy SHALL:
- set sticky dmistat = 3;
- issue no request;
- leave the pending request untouched.
REQ-027 Update-DR with DMI selected and op = 0 or 3 SHALL issue no request.
REQ-028 Entering Test-Logic-Reset (e.g. 5 TCK edges with TMS = 1) SHALL:
- set ir_reg = 0x01;
- clear sticky dmistat;
- not cancel an in-flight DMI request.
REQ-029 A TCK edge and dm_resp_valid in the same clk SHALL both be processed.
- A capture in that cycle SHALL observe the new resp_data and busy = 0.

Reset
REQ-030 On rst = 0, asynchronously, the module SHALL reset to:
- TAP state Test-Logic-Reset; ir_reg = 0x01;
- shift registers 0, resp_data 0, last_addr 0;
- busy 0, sticky 0;
- dtm_req_valid 0, dtm_req_data 0, jtag_TDO 0;
- synchronizers cleared (TCK treated low).
REQ-031 After rst deasserts, the first synchronized TCK rising edge SHALL be the first FSM transition.
- Assertion mid-shift SHALL discard the partial shift.

Verification
REQ-032 Reset, then IR left at default, scan 32 bits of DR -> TDO stream equals 0x1E200A6D, LSB first.
REQ-033 IR scan 5'b10000, then DR scan -> captured DTMCS = 0x00005061, dmistat 0.
REQ-034 IR = 0x11, DMI scan {6'h10, 32'h0, 2'b10} -> dtm_req_valid rises 1 clk after Update-DR with dtm_req_data = 40'h4000000002.
- Held until ready, then drops the next clk.
REQ-035 DMI read {6'h11, 0, 2'b01}; DM returns dm_resp_valid with 0xDEADBEEF -> next DMI scan (op 0) shifts out data[33:2] = 0xDEADBEEF, addr 0x11, status 0.
REQ-036 Second DMI update while dtm_req_ready is held 0 -> no new request, captured status = 3.
- After DTMCS write with bit 16 = 1 and the response, status = 0.
REQ-037 rst pulsed low mid Shift-DR -> all outputs return to reset values immediately.
- IDCODE reads correctly after reset deasserts.
